// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-lite master port.
// One transaction in flight; each wait state is bounded by TIMEOUT cycles.
module axi_lite_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [4:0]  m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  input  logic [1:0]  m_response,
  output logic        m_bready,
  output logic [4:0]  m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        m_rready
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last_grant, last_grant_d;
  logic          owner, owner_d;
  logic [AW-1:0] txn_addr, txn_addr_d;
  logic [DW-1:0] txn_wdata, txn_wdata_d;

  logic          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [1:0]    rsp_valid_d, rsp_resp_d;
  logic [DW-1:0] rsp_rdata_d;

  logic          gnt_idx;
  logic          timeout_hit;
  logic          aw_left, w_left;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    if (req_valid == 2'b11) gnt_idx = ~last_grant;
    else                    gnt_idx = req_valid[1];
  end

  assign req_ready   = (state == IDLE && !reset && (|req_valid))
                       ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign timeout_hit = (cnt >= CW'(TIMEOUT - 1));
  assign aw_left     = m_awvalid & ~m_awready;
  assign w_left      = m_wvalid & ~m_wready;

  // Next-state and next-output logic; every m_* strobe defaults low.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_grant_d = last_grant;
    owner_d      = owner;
    txn_addr_d   = txn_addr;
    txn_wdata_d  = txn_wdata;
    awvalid_d    = 1'b0;
    wvalid_d     = 1'b0;
    bready_d     = 1'b0;
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    rsp_valid_d  = 2'b00;
    rsp_resp_d   = rsp_resp;
    rsp_rdata_d  = rsp_rdata;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          last_grant_d = gnt_idx;
          owner_d      = gnt_idx;
          txn_addr_d   = gnt_idx ? req_addr[9:5] : req_addr[4:0];
          txn_wdata_d  = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
          if (req_write[gnt_idx]) begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W retire independently; leave once neither is pending.
      WR_ADDR: begin
        if (!aw_left && !w_left) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          state_d     = DONE;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          awvalid_d = aw_left;
          wvalid_d  = w_left;
          cnt_d     = cnt + CW'(1);
        end
      end

      WR_RESP: begin
        if (m_bvalid && m_bready) begin
          state_d     = DONE;
          rsp_resp_d  = m_response;
          rsp_rdata_d = '0;
        end else if (timeout_hit) begin
          state_d     = DONE;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          bready_d = 1'b1;
          cnt_d    = cnt + CW'(1);
        end
      end

      RD_ADDR: begin
        if (m_arvalid && m_arready) begin
          state_d  = RD_DATA;
          rready_d = 1'b1;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          state_d     = DONE;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          arvalid_d = 1'b1;
          cnt_d     = cnt + CW'(1);
        end
      end

      RD_DATA: begin
        if (m_rvalid && m_rready) begin
          state_d     = DONE;
          rsp_resp_d  = RESP_OKAY;
          rsp_rdata_d = m_rdata;
        end else if (timeout_hit) begin
          state_d     = DONE;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          rready_d = 1'b1;
          cnt_d    = cnt + CW'(1);
        end
      end

      DONE: begin
        rsp_valid_d = owner ? 2'b10 : 2'b01;
        state_d     = IDLE;
        cnt_d       = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, transaction latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      txn_addr   <= '0;
      txn_wdata  <= '0;
      m_awaddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_resp   <= 2'b00;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_grant <= last_grant_d;
      owner      <= owner_d;
      txn_addr   <= txn_addr_d;
      txn_wdata  <= txn_wdata_d;
      m_awaddr   <= awvalid_d ? txn_addr_d : '0;
      m_awvalid  <= awvalid_d;
      m_wdata    <= wvalid_d ? txn_wdata_d : '0;
      m_wvalid   <= wvalid_d;
      m_bready   <= bready_d;
      m_araddr   <= arvalid_d ? txn_addr_d : '0;
      m_arvalid  <= arvalid_d;
      m_rready   <= rready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_resp   <= rsp_resp_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset; all state SHALL clear immediately when reset rises.
REQ-002 TIMEOUT, 255, SHALL set the maximum cycles spent waiting in any wait state; legal values are 1-65535 and it SHALL count in 16 bits.
REQ-003 clk  in  1  system clock; all flops SHALL be rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester transaction request; bit i belongs to requester i.
REQ-006 req_write  in  2  per-requester: 1 = write, 0 = read.
REQ-007 req_addr  in  10  word address, requester i at bits [5i+4:5i].
REQ-008 req_wdata  in  64  write data, requester i at bits [32i+31:32i].
REQ-009 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-010 rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-011 rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes.
REQ-012 rsp_resp  out  2  00 = OKAY, else the slave response or 10 on timeout.
REQ-013 m_awaddr/m_awvalid out 5/1 and m_awready in 1 SHALL form the slave write-address channel; m_awaddr maps to slave address bits [6:2].
REQ-014 m_wdata/m_wvalid out 32/1 and m_wready in 1 SHALL form the write-data channel.
REQ-015 m_bvalid in 1, m_response in 2 and m_bready out 1 SHALL form the write-response channel.
REQ-016 m_araddr/m_arvalid out 5/1 and m_arready in 1 SHALL form the read-address channel.
REQ-017 m_rvalid in 1, m_rdata in 32 and m_rready out 1 SHALL form the read-data channel.

Function
REQ-018 The FSM SHALL have six states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE; only one transaction SHALL be outstanding at a time.
REQ-019 In IDLE, with any req_valid set, the block SHALL grant one requester and pulse its req_ready that cycle.
- On the same edge it SHALL latch write, addr, wdata and the grant index.
- It SHALL move to WR_ADDR or RD_ADDR.
REQ-020 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last SHALL win; a lone requester SHALL always win.
REQ-021 In WR_ADDR, m_awvalid and m_wvalid SHALL be asserted (registered) from the first cycle in the state.
- Each SHALL drop on the edge where its own handshake completes; AW and W MAY complete in different cycles.
- When both are done, the FSM SHALL move to WR_RESP.
REQ-022 In WR_RESP, m_bready SHALL be 1; on m_bvalid&m_bready the block SHALL capture m_response into rsp_resp and move to DONE.
REQ-023 In RD_ADDR, m_arvalid SHALL be 1 until m_arvalid&m_arready, then the FSM SHALL move to RD_DATA.
REQ-024 In RD_DATA, m_rready SHALL be 1; on m_rvalid the block SHALL capture m_rdata, set rsp_resp = 00 and move to DONE.
REQ-025 In DONE, rsp_valid[grant] SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; the next grant SHALL occur no earlier than the cycle after DONE.
REQ-026 With an always-ready slave, a read SHALL complete with rsp_valid at cycle 4 after the grant cycle (grant = cycle 0).
REQ-027 With an always-ready slave, a write SHALL likewise complete with rsp_valid at cycle 4.
REQ-028 A wait counter SHALL clear on entry to each of WR_ADDR, WR_RESP, RD_ADDR and RD_DATA, and SHALL increment each cycle spent in that state.
- When it reaches TIMEOUT, the block SHALL deassert all m_*valid and m_*ready, set rsp_resp = 10 and rsp_rdata = 0, and move to DONE.
REQ-029 Changes to req_valid, req_addr or req_wdata after the grant SHALL NOT affect the transaction in flight.
- A requester SHALL hold req_valid until it sees req_ready.
REQ-030 All m_* outputs, req_ready and rsp_valid SHALL be 0 in any state where this document does not assert them.

Reset
REQ-031 On reset the block SHALL:
- set the state to IDLE;
- set all outputs to 0;
- clear the wait counter;
- set the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-032 A reset mid-transaction SHALL abandon the transaction without issuing rsp_valid.

Verification
REQ-033 Read with both requesters valid after reset, slave always ready, addr0 = 3, m_rdata = 0xDEADBEEF -> req_ready = 01, m_araddr = 3, rsp_valid = 01 at cycle 4, rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
REQ-034 Both requesters write back-to-back -> grants alternate 01, 10, 01; each rsp_valid pulses once to the owner; m_wdata matches that requester's data.
REQ-035 Write with m_awready delayed 3 cycles and m_wready immediate -> m_wvalid drops after 1 cycle; m_awvalid holds 3 cycles; the FSM enters WR_RESP only after both handshakes; m_response = 10 is reflected in rsp_resp.
REQ-036 TIMEOUT = 4, read with m_arready held 0 -> m_arvalid drops after 4 cycles; rsp_valid pulses with rsp_resp = 10 and rsp_rdata = 0.
REQ-037 Reset asserted in RD_DATA -> all outputs 0 immediately; no rsp_valid; the next request is granted normally.
